// File: rtl/spike_if_pkg.sv
// rtl/spike_if_pkg.sv - shared types and saturating helper for the spike decoder
package spike_if_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic {IDLE, RUN} state_t;

  // Increment v but hold at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] lim;
    lim = (32'd1 << w) - 32'd1;
    return (v >= lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/spike_edge_det.sv
// rtl/spike_edge_det.sv - rising-edge detector on the level-sampled spike stream
module spike_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic spike_in,
  output logic spike_edge
);

  logic r_spike_d;

  always_ff @(posedge clk) begin
    if (rst) r_spike_d <= 1'b0;
    else     r_spike_d <= spike_in;
  end

  assign spike_edge = spike_in & ~r_spike_d;

endmodule

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed spike-rate counter with ISI readout and valid/ready output
module spike_rate_decoder
  import spike_if_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  input  logic [7:0]       window_len,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic [CNT_W-1:0] isi_out,
  output logic             isi_valid,
  output logic             drop
);

  state_t           r_state;
  logic [8:0]       r_len_q;
  logic [7:0]       r_win_cnt;
  logic [CNT_W-1:0] r_spk_cnt;
  logic [CNT_W-1:0] r_isi_cnt;
  logic             r_armed;
  logic [CNT_W-1:0] r_rate_out;
  logic             r_rate_valid;
  logic [CNT_W-1:0] r_isi_out;
  logic             r_isi_valid;
  logic             r_drop;

  logic             w_edge;
  logic [8:0]       w_len_sel;
  logic             w_last;
  logic             w_complete;
  logic [CNT_W-1:0] w_spk_next;
  logic [CNT_W-1:0] w_isi_inc;

  spike_edge_det u_edge (
    .clk        (clk),
    .rst        (rst),
    .spike_in   (spike_in),
    .spike_edge (w_edge)
  );

  // A programmed length of 0 stands for the full 256-cycle window.
  assign w_len_sel  = (window_len == 8'd0) ? 9'd256 : {1'b0, window_len};
  assign w_last     = ({1'b0, r_win_cnt} == (r_len_q - 9'd1));
  assign w_complete = (r_state == RUN) && en && w_last;
  assign w_spk_next = w_edge ? CNT_W'(sat_inc(32'(r_spk_cnt), CNT_W)) : r_spk_cnt;
  assign w_isi_inc  = CNT_W'(sat_inc(32'(r_isi_cnt), CNT_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_len_q      <= '0;
      r_win_cnt    <= '0;
      r_spk_cnt    <= '0;
      r_isi_cnt    <= '0;
      r_armed      <= 1'b0;
      r_rate_out   <= '0;
      r_rate_valid <= 1'b0;
      r_isi_out    <= '0;
      r_isi_valid  <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      if (r_rate_valid && rate_ready && !w_complete) r_rate_valid <= 1'b0;

      if (r_state == IDLE) begin
        if (en) begin
          r_state   <= RUN;
          r_win_cnt <= '0;
          r_spk_cnt <= '0;
          r_len_q   <= w_len_sel;
          r_isi_cnt <= '0;
          r_armed   <= 1'b0;
        end
      end else if (!en) begin
        r_state <= IDLE;
        r_armed <= 1'b0;
      end else begin
        if (w_last) begin
          r_rate_out   <= w_spk_next;
          r_rate_valid <= 1'b1;
          if (r_rate_valid && !rate_ready) r_drop <= 1'b1;
          r_spk_cnt    <= '0;
          r_win_cnt    <= '0;
          r_len_q      <= w_len_sel;
        end else begin
          r_win_cnt <= r_win_cnt + 8'd1;
          r_spk_cnt <= w_spk_next;
        end

        // The first edge after entering RUN only arms the interval counter.
        if (w_edge) begin
          r_isi_cnt <= '0;
          r_armed   <= 1'b1;
          if (r_armed) begin
            r_isi_out   <= w_isi_inc;
            r_isi_valid <= 1'b1;
          end
        end else begin
          r_isi_cnt <= w_isi_inc;
        end
      end
    end
  end

  assign rate_out   = r_rate_out;
  assign rate_valid = r_rate_valid;
  assign isi_out    = r_isi_out;
  assign isi_valid  = r_isi_valid;
  assign drop       = r_drop;

endmodule
